// File: rtl/pipe_addsub.sv
// pipe_addsub: pipelined integer adder/subtractor, CHUNK bits per stage,
// registered carry chain, valid/ready handshake with global stall.
module pipe_addsub #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_sub,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_ovf,
    output logic             o_zero,
    output logic             o_neg
);

    localparam int STAGES = WIDTH / CHUNK;
    localparam int LAST   = STAGES - 1;

    logic                          en;

    // Stage output registers, index k = output of stage k
    logic [STAGES-1:0]             r_v;
    logic [STAGES-1:0]             r_sub;
    logic [STAGES-1:0]             r_c;
    logic [STAGES-1:0][WIDTH-1:0]  r_a;
    logic [STAGES-1:0][WIDTH-1:0]  r_b;
    logic [STAGES-1:0][WIDTH-1:0]  r_s;

    // Stage input chains, index k = input of stage k
    logic [STAGES:0]               ch_v;
    logic [STAGES:0]               ch_sub;
    logic [STAGES:0]               ch_c;
    logic [STAGES:0][WIDTH-1:0]    ch_a;
    logic [STAGES:0][WIDTH-1:0]    ch_b;
    logic [STAGES:0][WIDTH-1:0]    ch_s;

    // Per-stage chunk arithmetic
    logic [STAGES-1:0][CHUNK-1:0]  ca;
    logic [STAGES-1:0][CHUNK-1:0]  cb;
    logic [STAGES-1:0][CHUNK:0]    t;
    logic [STAGES-1:0][WIDTH-1:0]  ns;

    // Last-stage flag inputs
    logic                          l_cout;
    logic                          l_cmsb;
    logic                          l_v;

    logic                          f_cout;
    logic                          f_ovf;
    logic                          f_zero;
    logic                          f_neg;

    // Whole pipe advances together unless the held result is refused
    assign en      = ~o_valid | i_ready;
    assign o_ready = en;

    // Stage 0 takes the ports; stage k takes stage k-1's registers.
    // The carry into stage 0 is the subtract flag (two's complement +1).
    assign ch_v   = {r_v,   i_valid};
    assign ch_sub = {r_sub, i_sub};
    assign ch_c   = {r_c,   i_sub};
    assign ch_a   = {r_a,   i_a};
    assign ch_b   = {r_b,   i_b};
    assign ch_s   = {r_s,   {WIDTH{1'b0}}};

    // Ripple-add this stage's chunk and merge it into the de-skewed sum
    always_comb begin
        ca = '0;
        cb = '0;
        t  = '0;
        ns = '0;
        for (int k = 0; k < STAGES; k++) begin
            ca[k] = ch_a[k][k*CHUNK +: CHUNK];
            cb[k] = ch_b[k][k*CHUNK +: CHUNK] ^ {CHUNK{ch_sub[k]}};
            t[k]  = {1'b0, ca[k]} + {1'b0, cb[k]}
                  + {{CHUNK{1'b0}}, ch_c[k]};
            ns[k] = ch_s[k];
            ns[k][k*CHUNK +: CHUNK] = t[k][CHUNK-1:0];
        end
    end

    // Carry into the MSB recovered from the MSB sum bit and its operands
    always_comb begin
        l_v    = ch_v[LAST];
        l_cout = t[LAST][CHUNK];
        l_cmsb = t[LAST][CHUNK-1]
               ^ ca[LAST][CHUNK-1]
               ^ cb[LAST][CHUNK-1];
    end

    // Pipeline registers; last-stage result and flags load only on valid
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_v    <= '0;
            r_sub  <= '0;
            r_c    <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_s    <= '0;
            f_cout <= 1'b0;
            f_ovf  <= 1'b0;
            f_zero <= 1'b0;
            f_neg  <= 1'b0;
        end else if (en) begin
            r_v   <= ch_v[STAGES-1:0];
            r_sub <= ch_sub[STAGES-1:0];
            r_a   <= ch_a[STAGES-1:0];
            r_b   <= ch_b[STAGES-1:0];
            for (int k = 0; k < STAGES; k++) begin
                r_c[k] <= t[k][CHUNK];
            end
            for (int k = 0; k < LAST; k++) begin
                r_s[k] <= ns[k];
            end
            if (l_v) begin
                r_s[LAST] <= ns[LAST];
                f_cout    <= l_cout ^ ch_sub[LAST];
                f_ovf     <= l_cmsb ^ l_cout;
                f_zero    <= ~|ns[LAST];
                f_neg     <= ns[LAST][WIDTH-1];
            end
        end
    end

    assign o_valid = r_v[LAST];
    assign o_sum   = r_s[LAST];
    assign o_cout  = f_cout;
    assign o_ovf   = f_ovf;
    assign o_zero  = f_zero;
    assign o_neg   = f_neg;

endmodule

// File: tb/tb_pipe_addsub.sv
// tb_pipe_addsub: directed and randomized checks of pipe_addsub
// against a plain-arithmetic reference model.
module tb_pipe_addsub;

    typedef struct packed {
        logic [31:0] s;
        logic        c;
        logic        o;
        logic        z;
        logic        n;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        v0, rdy0, ordy0, sub0, ov0, c0, of0, z0, n0;
    logic [31:0] a0, b0, s0;
    logic        v1, rdy1, ordy1, sub1, ov1, c1, of1, z1, n1;
    logic [31:0] a1, b1, s1;

    int checks = 0;
    int passes = 0;

    res_t q[$];

    always #5 clk = ~clk;

    pipe_addsub #(.WIDTH(32), .CHUNK(8)) u0 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_valid(v0), .o_ready(ordy0),
        .i_a(a0), .i_b(b0), .i_sub(sub0),
        .o_valid(ov0), .i_ready(rdy0),
        .o_sum(s0), .o_cout(c0), .o_ovf(of0),
        .o_zero(z0), .o_neg(n0)
    );

    pipe_addsub #(.WIDTH(32), .CHUNK(32)) u1 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_valid(v1), .o_ready(ordy1),
        .i_a(a1), .i_b(b1), .i_sub(sub1),
        .o_valid(ov1), .i_ready(rdy1),
        .o_sum(s1), .o_cout(c1), .o_ovf(of1),
        .o_zero(z1), .o_neg(n1)
    );

    function automatic res_t model(input logic [31:0] a,
                                   input logic [31:0] b,
                                   input logic sub);
        res_t        r;
        logic [32:0] full;
        if (!sub) begin
            full = {1'b0, a} + {1'b0, b};
            r.s  = full[31:0];
            r.c  = full[32];
            r.o  = (a[31] == b[31]) && (r.s[31] != a[31]);
        end else begin
            r.s  = a - b;
            r.c  = (a < b);
            r.o  = (a[31] != b[31]) && (r.s[31] != a[31]);
        end
        r.z = (r.s == 32'd0);
        r.n = r.s[31];
        return r;
    endfunction

    // One op with i_ready=1; returns the first result and its latency
    task automatic do_op(input bit which, input logic [31:0] a,
                         input logic [31:0] b, input logic sub,
                         output res_t obs, output int lat);
        @(negedge clk);
        if (!which) begin
            v0 = 1'b1; a0 = a; b0 = b; sub0 = sub; rdy0 = 1'b1;
        end else begin
            v1 = 1'b1; a1 = a; b1 = b; sub1 = sub; rdy1 = 1'b1;
        end
        @(posedge clk);
        #1;
        v0 = 1'b0;
        v1 = 1'b0;
        lat = -1;
        obs = '0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (which ? ov1 : ov0) begin
                lat = i;
                obs = which ? {s1, c1, of1, z1, n1}
                            : {s0, c0, of0, z0, n0};
                break;
            end
        end
    endtask

    task automatic test_reset;
        res_t o0;
        res_t o1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        o0 = {s0, c0, of0, z0, n0};
        o1 = {s1, c1, of1, z1, n1};
        checks++;
        if (ov0 !== 1'b0 || o0 !== '0 || ordy0 !== 1'b1) begin
            $display("FAIL reset_u0: valid=%b out=%h ready=%b want 0 0 1",
                     ov0, o0, ordy0);
        end else passes++;
        checks++;
        if (ov1 !== 1'b0 || o1 !== '0 || ordy1 !== 1'b1) begin
            $display("FAIL reset_u1: valid=%b out=%h ready=%b want 0 0 1",
                     ov1, o1, ordy1);
        end else passes++;
        rst_n = 1'b1;
    endtask

    task automatic test_add;
        res_t obs;
        int   lat;
        do_op(1'b0, 32'd5, 32'd3, 1'b0, obs, lat);
        checks++;
        if (lat !== 4) begin
            $display("FAIL add_latency: got %0d want 4", lat);
        end else passes++;
        checks++;
        if (obs !== {32'd8, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            $display("FAIL add_5_3: got %h want %h", obs,
                     {32'd8, 4'b0000});
        end else passes++;
    endtask

    task automatic test_sub;
        res_t obs;
        int   lat;
        do_op(1'b0, 32'd3, 32'd5, 1'b1, obs, lat);
        checks++;
        if (lat !== 4 ||
            obs !== {32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0, 1'b1}) begin
            $display("FAIL sub_3_5: got %h lat %0d want %h lat 4", obs, lat,
                     {32'hFFFF_FFFE, 4'b1001});
        end else passes++;
        do_op(1'b0, 32'd5, 32'd3, 1'b1, obs, lat);
        checks++;
        if (lat !== 4 || obs !== {32'd2, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            $display("FAIL sub_5_3: got %h lat %0d want %h lat 4", obs, lat,
                     {32'd2, 4'b0000});
        end else passes++;
    endtask

    task automatic test_ovf_wrap;
        res_t obs;
        int   lat;
        do_op(1'b0, 32'h7FFF_FFFF, 32'd1, 1'b0, obs, lat);
        checks++;
        if (obs !== {32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1}) begin
            $display("FAIL ovf_pos: got %h want %h", obs,
                     {32'h8000_0000, 4'b0101});
        end else passes++;
        do_op(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0, obs, lat);
        checks++;
        if (obs !== {32'd0, 1'b1, 1'b0, 1'b1, 1'b0}) begin
            $display("FAIL wrap: got %h want %h", obs, {32'd0, 4'b1010});
        end else passes++;
        do_op(1'b0, 32'h8000_0000, 32'd1, 1'b1, obs, lat);
        checks++;
        if (obs !== {32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            $display("FAIL ovf_sub: got %h want %h", obs,
                     {32'h7FFF_FFFF, 4'b0100});
        end else passes++;
    endtask

    task automatic test_chunk_carry;
        res_t obs;
        int   lat;
        do_op(1'b0, 32'h0000_00FF, 32'd1, 1'b0, obs, lat);
        checks++;
        if (obs !== {32'h0000_0100, 4'b0000}) begin
            $display("FAIL chunk_carry: got %h want %h", obs,
                     {32'h0000_0100, 4'b0000});
        end else passes++;
        do_op(1'b0, 32'h00FF_FFFF, 32'd1, 1'b0, obs, lat);
        checks++;
        if (obs !== {32'h0100_0000, 4'b0000}) begin
            $display("FAIL chunk_ripple: got %h want %h", obs,
                     {32'h0100_0000, 4'b0000});
        end else passes++;
    endtask

    task automatic test_backpressure;
        res_t cur;
        res_t snap;
        res_t exp_r;
        int   sent;
        int   got;
        bit   stall;
        bit   taken;
        sent  = 0;
        got   = 0;
        stall = 1'b0;
        taken = 1'b1;
        snap  = '0;
        q.delete();
        for (int cyc = 0; cyc < 3000 && got < 64; cyc++) begin
            @(negedge clk);
            if (sent < 64) begin
                if (taken) begin
                    a0   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF
                                                        : $urandom;
                    b0   = $urandom;
                    sub0 = 1'($urandom_range(0, 1));
                end
                v0 = 1'b1;
            end else begin
                v0 = 1'b0;
            end
            rdy0 = 1'($urandom_range(0, 1));
            #1;
            cur = {s0, c0, of0, z0, n0};
            checks++;
            if (ordy0 !== (~ov0 | rdy0)) begin
                $display("FAIL bp_ready: got %b want %b", ordy0,
                         ~ov0 | rdy0);
            end else passes++;
            if (stall) begin
                checks++;
                if (ov0 !== 1'b1 || cur !== snap) begin
                    $display("FAIL bp_stable: got %b/%h want 1/%h",
                             ov0, cur, snap);
                end else passes++;
            end
            if (ov0 && rdy0) begin
                checks++;
                if (q.size() == 0) begin
                    $display("FAIL bp_extra: got %h want none", cur);
                end else begin
                    exp_r = q.pop_front();
                    if (cur !== exp_r) begin
                        $display("FAIL bp_result %0d: got %h want %h",
                                 got, cur, exp_r);
                    end else passes++;
                end
                got++;
            end
            taken = 1'b0;
            if (v0 && ordy0) begin
                q.push_back(model(a0, b0, sub0));
                sent++;
                taken = 1'b1;
            end
            stall = ov0 && !rdy0;
            snap  = cur;
        end
        v0   = 1'b0;
        rdy0 = 1'b1;
        checks++;
        if (got !== 64 || q.size() !== 0) begin
            $display("FAIL bp_count: got %0d left %0d want 64 left 0",
                     got, q.size());
        end else passes++;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        res_t obs;
        int   lat;
        rdy0 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            v0   = 1'b1;
            a0   = 32'h100 + i;
            b0   = i;
            sub0 = 1'b0;
        end
        @(negedge clk);
        v0 = 1'b0;
        #1;
        checks++;
        if (ov0 !== 1'b1 || s0 !== 32'h100) begin
            $display("FAIL rst_pre: got %b/%h want 1/%h", ov0, s0,
                     32'h100);
        end else passes++;
        rst_n = 1'b0;
        #1;
        obs = {s0, c0, of0, z0, n0};
        checks++;
        if (ov0 !== 1'b0 || obs !== '0) begin
            $display("FAIL rst_mid: got %b/%h want 0/0", ov0, obs);
        end else passes++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_op(1'b0, 32'd7, 32'd9, 1'b0, obs, lat);
        checks++;
        if (lat !== 4 || obs !== {32'd16, 4'b0000}) begin
            $display("FAIL rst_after: got %h lat %0d want %h lat 4",
                     obs, lat, {32'd16, 4'b0000});
        end else passes++;
    endtask

    task automatic test_single_stage;
        res_t        obs;
        res_t        exp_r;
        int          lat;
        logic [31:0] ra;
        logic [31:0] rb;
        do_op(1'b1, 32'd0, 32'd0, 1'b1, obs, lat);
        checks++;
        if (lat !== 1 || obs !== {32'd0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            $display("FAIL single_sub0: got %h lat %0d want %h lat 1",
                     obs, lat, {32'd0, 4'b0010});
        end else passes++;
        for (int i = 0; i < 4; i++) begin
            ra    = $urandom;
            rb    = $urandom;
            exp_r = model(ra, rb, 1'(i % 2));
            do_op(1'b1, ra, rb, 1'(i % 2), obs, lat);
            checks++;
            if (lat !== 1 || obs !== exp_r) begin
                $display("FAIL single_rand %0d: got %h lat %0d want %h",
                         i, obs, lat, exp_r);
            end else passes++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        v0 = 1'b0; rdy0 = 1'b0; a0 = '0; b0 = '0; sub0 = 1'b0;
        v1 = 1'b0; rdy1 = 1'b1; a1 = '0; b1 = '0; sub1 = 1'b0;
        test_reset();
        test_add();
        test_sub();
        test_ovf_wrap();
        test_chunk_carry();
        test_backpressure();
        test_reset_mid();
        test_single_stage();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
